shift_reg2_seq: RTL and testbench

Command sequencer for the 8-bit shift_reg2 datapath.
- Accepts (mode, data, count) commands over a valid/ready handshake.
- Drives the register's enable, shift_direction and data_in for exactly `count` enabled cycles.
- Returns the resulting register contents on a valid/ready response channel.
- Sits between the control bus and the shift_reg2 instance; it is the sole driver of that instance's inputs.

---
 rtl/shift_reg2_seq_if.sv | 29 ++
 rtl/shift_reg2_seq.sv | 111 +++++++++++
 tb/tb_shift_reg2_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg2_seq_if.sv
// Command and response channels between the control bus and shift_reg2_seq.
// The master side issues commands and consumes results; the slave is the sequencer.
interface shift_reg2_seq_if #(
  parameter int DATA_W  = 8,
  parameter int MODE_W  = 3,
  parameter int COUNT_W = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [MODE_W-1:0]  cmd_mode;
  logic [DATA_W-1:0]  cmd_data;
  logic [COUNT_W-1:0] cmd_count;
  logic               abort;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_data;
  logic [COUNT_W-1:0] rsp_steps;
  logic               rsp_aborted;

  modport master (
    output cmd_valid, cmd_mode, cmd_data, cmd_count, abort, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_steps, rsp_aborted
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_data, cmd_count, abort, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_steps, rsp_aborted
  );
endinterface

// File: rtl/shift_reg2_seq.sv
// Command sequencer driving shift_reg2 enable/direction/data for `count` enabled cycles.
// Latency: enables T+1..T+count, response valid at T+count+1 (T+1 for count 0).
// Backpressure: response held until rsp_ready; no new command accepted until then.
module shift_reg2_seq #(
  parameter int DATA_W  = 8,
  parameter int MODE_W  = 3,
  parameter int COUNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  shift_reg2_seq_if.slave     bus,
  output logic                sr_enable,
  output logic [MODE_W-1:0]   sr_shift_dir,
  output logic [DATA_W-1:0]   sr_data_in,
  input  logic [DATA_W-1:0]   sr_data_out,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t             state, state_nxt;
  logic [COUNT_W-1:0] remaining, remaining_nxt;
  logic [COUNT_W-1:0] steps, steps_nxt;
  logic               enable_nxt;
  logic [MODE_W-1:0]  dir_nxt;
  logic [DATA_W-1:0]  din_nxt;
  logic               rsp_valid_q, rsp_valid_nxt;
  logic               rsp_aborted_q, aborted_nxt;
  logic               last_step;

  assign last_step       = (remaining == COUNT_W'(1));
  assign bus.cmd_ready   = (state == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_steps   = steps;
  assign bus.rsp_aborted = rsp_aborted_q;
  // Datapath is frozen while a response is pending, so this passthrough is stable.
  assign bus.rsp_data    = rsp_valid_q ? sr_data_out : '0;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    steps_nxt     = steps;
    enable_nxt    = sr_enable;
    dir_nxt       = sr_shift_dir;
    din_nxt       = sr_data_in;
    rsp_valid_nxt = rsp_valid_q;
    aborted_nxt   = rsp_aborted_q;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          dir_nxt       = bus.cmd_mode;
          din_nxt       = bus.cmd_data;
          remaining_nxt = bus.cmd_count;
          steps_nxt     = '0;
          aborted_nxt   = 1'b0;
          if (bus.cmd_count == '0) begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            enable_nxt    = 1'b0;
          end else begin
            state_nxt  = RUN;
            enable_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        steps_nxt     = steps + COUNT_W'(1);
        remaining_nxt = remaining - COUNT_W'(1);
        // The current cycle's enable is already committed, so abort only stops later ones.
        if (last_step || bus.abort) begin
          state_nxt     = RESP;
          enable_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          aborted_nxt   = bus.abort && !last_step;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      remaining     <= '0;
      steps         <= '0;
      sr_enable     <= 1'b0;
      sr_shift_dir  <= '0;
      sr_data_in    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_aborted_q <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      remaining     <= remaining_nxt;
      steps         <= steps_nxt;
      sr_enable     <= enable_nxt;
      sr_shift_dir  <= dir_nxt;
      sr_data_in    <= din_nxt;
      rsp_valid_q   <= rsp_valid_nxt;
      rsp_aborted_q <= aborted_nxt;
      busy          <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_shift_reg2_seq.sv
// Randomized bench for shift_reg2_seq with a stand-in shift_reg2 datapath and a timeline model.
module tb_shift_reg2_seq;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sr_enable, busy;
  logic [2:0] sr_shift_dir;
  logic [7:0] sr_data_in, sr_data_out, sr_q;

  shift_reg2_seq_if #(.DATA_W(8), .MODE_W(3), .COUNT_W(4)) bus();

  shift_reg2_seq #(.DATA_W(8), .MODE_W(3), .COUNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sr_enable(sr_enable), .sr_shift_dir(sr_shift_dir), .sr_data_in(sr_data_in),
    .sr_data_out(sr_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  bit chk_on = 0;
  bit exp_en[MAXC], exp_rv[MAXC], exp_cr[MAXC], exp_busy[MAXC];
  logic [2:0] cur_mode;
  logic [7:0] cur_data, cur_exp;
  int cur_n;
  bit cur_ab;
  int en_seen, rv_off, cap_steps, cap_ab, cap_data;
  bit rv_seen;

  function automatic logic [7:0] op(input logic [7:0] r, input logic [2:0] m, input logic [7:0] d);
    case (m)
      3'd0:    return r + d;
      3'd1:    return {r[6:0], r[7]};
      3'd2:    return {r[0], r[7:1]};
      3'd3:    return r ^ d;
      default: return {r[6:0], d[0]};
    endcase
  endfunction

  // Stand-in for the shift_reg2 instance the sequencer drives.
  always @(posedge clk) begin
    if (!reset) sr_q <= 8'h00;
    else if (sr_enable) sr_q <= op(sr_q, sr_shift_dir, sr_data_in);
  end
  assign sr_data_out = sr_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      chk("sr_enable", int'(sr_enable), int'(exp_en[cyc]));
      chk("rsp_valid", int'(bus.rsp_valid), int'(exp_rv[cyc]));
      chk("cmd_ready", int'(bus.cmd_ready), int'(exp_cr[cyc]));
      chk("busy", int'(busy), int'(exp_busy[cyc]));
      if (exp_busy[cyc]) begin
        chk("sr_shift_dir", int'(sr_shift_dir), int'(cur_mode));
        chk("sr_data_in", int'(sr_data_in), int'(cur_data));
      end
      if (exp_rv[cyc]) begin
        chk("rsp_steps", int'(bus.rsp_steps), cur_n);
        chk("rsp_aborted", int'(bus.rsp_aborted), int'(cur_ab));
        chk("rsp_data", int'(bus.rsp_data), int'(cur_exp));
      end else begin
        chk("rsp_data_idle", int'(bus.rsp_data), 0);
      end
    end
  end

  // Issue one command at the current idle cycle T; ab_at/rst_at are offsets from T (0 = none).
  task automatic run_cmd(input logic [2:0] m, input logic [7:0] d, input int c,
                         input int ab_at, input int rdy_d, input int rst_at);
    int t0, n, last;
    logic [7:0] e;
    bit rst_hit;
    t0 = cyc;
    n = (ab_at > 0 && ab_at < c) ? ab_at : c;
    e = sr_q;
    for (int i = 0; i < n; i++) e = op(e, m, d);
    cur_mode = m; cur_data = d; cur_n = n; cur_exp = e;
    cur_ab = (ab_at > 0 && ab_at < c);
    last = t0 + n + 1 + rdy_d;
    for (int k = t0 + 1; k <= last && k < MAXC; k++) begin
      exp_cr[k] = 1'b0; exp_busy[k] = 1'b1;
      exp_en[k] = (k <= t0 + n); exp_rv[k] = (k > t0 + n);
    end
    en_seen = 0; rv_seen = 0; rv_off = -1; rst_hit = 0;
    bus.cmd_valid = 1'b1; bus.cmd_mode = m; bus.cmd_data = d; bus.cmd_count = 4'(c);
    bus.abort = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    while (cyc <= last) begin
      if (sr_enable) en_seen++;
      if (bus.rsp_valid && !rv_seen) begin
        rv_seen = 1; rv_off = cyc - t0;
        cap_steps = int'(bus.rsp_steps); cap_ab = int'(bus.rsp_aborted); cap_data = int'(bus.rsp_data);
      end
      bus.abort = (ab_at != 0 && cyc == t0 + ab_at) || (cyc > t0 + n && $urandom_range(0, 3) == 0);
      bus.rsp_ready = (cyc == last);
      if (rst_at != 0 && cyc == t0 + rst_at) begin
        reset = 1'b0; rst_hit = 1;
        for (int k = cyc + 1; k <= last && k < MAXC; k++) begin
          exp_cr[k] = 1'b1; exp_busy[k] = 1'b0; exp_en[k] = 1'b0; exp_rv[k] = 1'b0;
        end
      end
      @(negedge clk);
      if (rst_hit) begin
        reset = 1'b1;
        break;
      end
    end
    bus.rsp_ready = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic idle_gap(input int k);
    for (int i = 0; i < k; i++) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_mode = 3'($urandom); bus.cmd_data = 8'($urandom); bus.cmd_count = 4'($urandom);
      bus.abort = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.abort = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      exp_en[k] = 0; exp_rv[k] = 0; exp_cr[k] = 1; exp_busy[k] = 0;
    end
    bus.cmd_valid = 0; bus.cmd_mode = 0; bus.cmd_data = 0; bus.cmd_count = 0;
    bus.abort = 0; bus.rsp_ready = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sr_enable", int'(sr_enable), 0);
    chk("rst_sr_shift_dir", int'(sr_shift_dir), 0);
    chk("rst_sr_data_in", int'(sr_data_in), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_steps", int'(bus.rsp_steps), 0);
    chk("rst_rsp_aborted", int'(bus.rsp_aborted), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    reset = 1'b1;
    chk_on = 1;
    @(negedge clk);

    run_cmd(3'd0, 8'hA5, 3, 0, 0, 0);
    chk("t1_rv_offset", rv_off, 4);
    chk("t1_enables", en_seen, 3);
    chk("t1_steps", cap_steps, 3);
    chk("t1_aborted", cap_ab, 0);
    chk("t1_data", cap_data, 'hEF);

    run_cmd(3'd1, 8'h00, 0, 0, 0, 0);
    chk("t2_rv_offset", rv_off, 1);
    chk("t2_enables", en_seen, 0);
    chk("t2_steps", cap_steps, 0);

    run_cmd(3'd0, 8'h0F, 10, 4, 0, 0);
    chk("t3_rv_offset", rv_off, 5);
    chk("t3_enables", en_seen, 4);
    chk("t3_steps", cap_steps, 4);
    chk("t3_aborted", cap_ab, 1);
    chk("t3_data", cap_data, 'h2B);

    run_cmd(3'd1, 8'h77, 2, 0, 5, 0);
    chk("t4_rv_offset", rv_off, 3);
    chk("t4_data", cap_data, 'hAC);

    run_cmd(3'd4, 8'h3C, 8, 0, 0, 2);
    chk("t5_enables", en_seen, 2);
    chk("t5_rsp_seen", int'(rv_seen), 0);
    chk("t5_busy", int'(busy), 0);
    run_cmd(3'd0, 8'h11, 1, 0, 0, 0);
    chk("t5b_rv_offset", rv_off, 2);
    chk("t5b_steps", cap_steps, 1);
    chk("t5b_data", cap_data, 'h11);

    run_cmd(3'd2, 8'h5A, 15, 15, 1, 0);
    chk("t6_enables", en_seen, 15);
    chk("t6_steps", cap_steps, 15);
    chk("t6_aborted", cap_ab, 0);
    chk("t6_rv_offset", rv_off, 16);
    chk("t6_data", cap_data, 'h22);

    for (int i = 0; i < 150; i++) begin
      int c, ab;
      c = $urandom_range(0, 15);
      ab = (c > 0 && $urandom_range(0, 9) < 3) ? $urandom_range(1, c) : 0;
      run_cmd(3'($urandom), 8'($urandom), c, ab, $urandom_range(0, 3), 0);
      idle_gap($urandom_range(0, 2));
    end

    idle_gap(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
